// File: rtl/fetch_queue_pkg.sv
// Shared constants and the entry layout for the fetch-to-decode queue.
package fetch_queue_pkg;

    localparam int          IMEM_SIZE      = 1024;
    localparam int          FETCHQ_DEPTH   = 4;
    localparam logic [31:0] FETCHQ_NOP_INS = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] ins;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue_mem.sv
// Entry storage: DEPTH x 64-bit array, synchronous write, asynchronous read.
// Not reset; the control logic never exposes an unwritten slot.
module fetch_queue_mem
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = FETCHQ_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             wr_en_i,
    input  logic [PTR_W-1:0] wr_addr_i,
    input  fq_entry_t        wr_dat_i,
    input  logic [PTR_W-1:0] rd_addr_i,
    output fq_entry_t        rd_dat_o
);

    fq_entry_t mem_q [DEPTH];

    always_ff @(posedge CLK) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_dat_i;
        end
    end

    assign rd_dat_o = mem_q[rd_addr_i];

endmodule

// File: rtl/fetch_queue.sv
// Fetch-to-decode decoupling FIFO; push visible on out_* one edge later, no bypass.
// in_ready depends only on occupancy, so a full queue refuses input even while popping.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int          DEPTH   = FETCHQ_DEPTH,
    parameter int          PTR_W   = $clog2(DEPTH),
    parameter logic [31:0] NOP_INS = FETCHQ_NOP_INS
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_pc4,
    input  logic [31:0]      in_ins,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_pc4,
    output logic [31:0]      out_ins,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             push;
    logic             pop;
    fq_entry_t        wr_dat;
    fq_entry_t        rd_dat;

    assign in_ready  = (count_q != FULL_CNT);
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;
    assign count     = count_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + (PTR_W+1)'(1);
                2'b01:   count_d = count_q - (PTR_W+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign wr_dat.pc4 = in_pc4;
    assign wr_dat.ins = in_ins;

    fetch_queue_mem #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .CLK       (CLK),
        .wr_en_i   (push),
        .wr_addr_i (wr_ptr_q),
        .wr_dat_i  (wr_dat),
        .rd_addr_i (rd_ptr_q),
        .rd_dat_o  (rd_dat)
    );

    // Empty queue shows a NOP so decode never latches stale or wrong-path data.
    assign out_pc4 = out_valid ? rd_dat.pc4 : 32'h0;
    assign out_ins = out_valid ? rd_dat.ins : NOP_INS;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: vector table plus hand sequences, checked against a queue model.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_pc4 = '0;
    logic [31:0]      in_ins = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      out_pc4;
    logic [31:0]      out_ins;
    logic [PTR_W:0]   count;

    fetch_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W), .NOP_INS(32'h0000_0000)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc4    (in_pc4),
        .in_ins    (in_ins),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc4   (out_pc4),
        .out_ins   (out_ins),
        .count     (count)
    );

    always #5 CLK = ~CLK;

    int tests  = 0;
    int failed = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Reference queue model, updated on the same edges as the DUT.
    fq_entry_t sb_q[$];
    fq_entry_t sb_ent;
    logic      sb_push, sb_pop;
    logic      chk_en = 1'b0;

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sb_q.delete();
        end else if (flush) begin
            sb_q.delete();
        end else begin
            sb_pop  = (sb_q.size() != 0) && out_ready;
            sb_push = in_valid && (sb_q.size() < DEPTH);
            if (sb_pop) begin
                sb_ent = sb_q.pop_front();
            end
            if (sb_push) begin
                sb_ent.pc4 = in_pc4;
                sb_ent.ins = in_ins;
                sb_q.push_back(sb_ent);
            end
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            check("sb_count", 64'(count), 64'(sb_q.size()));
            check("sb_out_valid", 64'(out_valid), 64'(sb_q.size() != 0));
            check("sb_in_ready", 64'(in_ready), 64'(sb_q.size() != DEPTH));
            if (sb_q.size() != 0) begin
                check("sb_head_pc4", 64'(out_pc4), 64'(sb_q[0].pc4));
                check("sb_head_ins", 64'(out_ins), 64'(sb_q[0].ins));
            end else begin
                check("sb_empty_pc4", 64'(out_pc4), 64'h0);
                check("sb_empty_ins", 64'(out_ins), 64'h0);
            end
        end
    end

    typedef struct {
        logic        fl;
        logic        iv;
        logic [31:0] pc4;
        logic [31:0] ins;
        logic        ordy;
        int          exp_cnt;
        logic        exp_ov;
        logic [31:0] exp_pc4;
    } vec_t;

    vec_t vt[16];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "timeout");
    end

    initial begin
        vt[0]  = '{1'b0, 1'b1, 32'd4,   32'h2008_0001, 1'b0, 1, 1'b1, 32'd4};
        vt[1]  = '{1'b0, 1'b1, 32'd8,   32'h2008_0002, 1'b0, 2, 1'b1, 32'd4};
        vt[2]  = '{1'b0, 1'b1, 32'd12,  32'h2008_0003, 1'b0, 3, 1'b1, 32'd4};
        vt[3]  = '{1'b0, 1'b1, 32'd16,  32'h2008_0004, 1'b0, 4, 1'b1, 32'd4};
        vt[4]  = '{1'b0, 1'b1, 32'd20,  32'h2008_0005, 1'b0, 4, 1'b1, 32'd4};
        vt[5]  = '{1'b0, 1'b1, 32'd20,  32'h2008_0005, 1'b1, 3, 1'b1, 32'd8};
        vt[6]  = '{1'b0, 1'b0, 32'd0,   32'h0,         1'b1, 2, 1'b1, 32'd12};
        vt[7]  = '{1'b0, 1'b0, 32'd0,   32'h0,         1'b1, 1, 1'b1, 32'd16};
        vt[8]  = '{1'b0, 1'b0, 32'd0,   32'h0,         1'b1, 0, 1'b0, 32'd0};
        vt[9]  = '{1'b0, 1'b0, 32'd0,   32'h0,         1'b1, 0, 1'b0, 32'd0};
        vt[10] = '{1'b0, 1'b1, 32'd100, 32'h0000_0011, 1'b0, 1, 1'b1, 32'd100};
        vt[11] = '{1'b0, 1'b1, 32'd104, 32'h0000_0012, 1'b0, 2, 1'b1, 32'd100};
        vt[12] = '{1'b0, 1'b1, 32'd108, 32'h0000_0013, 1'b0, 3, 1'b1, 32'd100};
        vt[13] = '{1'b1, 1'b1, 32'd40,  32'h0000_0014, 1'b1, 0, 1'b0, 32'd0};
        vt[14] = '{1'b0, 1'b1, 32'd44,  32'h0000_0015, 1'b0, 1, 1'b1, 32'd44};
        vt[15] = '{1'b0, 1'b0, 32'd0,   32'h0,         1'b1, 0, 1'b0, 32'd0};

        // Reset, then idle.
        #1 RST = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b1;
        chk_en = 1'b1;
        tick();
        check("idle_count", 64'(count), 64'd0);
        check("idle_out_valid", 64'(out_valid), 64'd0);
        check("idle_in_ready", 64'(in_ready), 64'd1);
        check("idle_out_ins", 64'(out_ins), 64'h0);
        check("idle_out_pc4", 64'(out_pc4), 64'h0);

        // Fill/drain, full-push/pop corner, empty pop, flush priority.
        for (int i = 0; i < 16; i++) begin
            flush     = vt[i].fl;
            in_valid  = vt[i].iv;
            in_pc4    = vt[i].pc4;
            in_ins    = vt[i].ins;
            out_ready = vt[i].ordy;
            tick();
            check($sformatf("vec%0d_count", i), 64'(count), 64'(vt[i].exp_cnt));
            check($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(vt[i].exp_ov));
            check($sformatf("vec%0d_out_pc4", i), 64'(out_pc4), 64'(vt[i].exp_pc4));
            check($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(vt[i].exp_cnt != DEPTH));
        end
        flush = 1'b0;

        // Streaming: occupancy holds at one, output trails input by a cycle.
        for (int i = 0; i < 10; i++) begin
            in_valid  = 1'b1;
            in_pc4    = 32'd200 + 32'(4 * i);
            in_ins    = 32'h2400_0000 + 32'(i);
            out_ready = 1'b1;
            tick();
            check($sformatf("stream%0d_count", i), 64'(count), 64'd1);
            check($sformatf("stream%0d_out_pc4", i), 64'(out_pc4), 64'(32'd200 + 32'(4 * i)));
        end
        in_valid = 1'b0;
        tick();
        check("stream_drain_count", 64'(count), 64'd0);

        // Asynchronous reset between edges with two entries held.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_pc4    = 32'd300;
        in_ins    = 32'h1111_0000;
        tick();
        in_pc4    = 32'd304;
        in_ins    = 32'h1111_0001;
        tick();
        in_valid  = 1'b0;
        check("arst_pre_count", 64'(count), 64'd2);
        #2 RST = 1'b0;
        #1;
        check("arst_count", 64'(count), 64'd0);
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_in_ready", 64'(in_ready), 64'd1);
        check("arst_out_ins", 64'(out_ins), 64'h0);
        check("arst_out_pc4", 64'(out_pc4), 64'h0);
        RST = 1'b1;
        tick();
        check("arst_post_count", 64'(count), 64'd0);

        // Queue still operates after the reset pulse.
        in_valid = 1'b1;
        in_pc4   = 32'd500;
        in_ins   = 32'h2222_0000;
        tick();
        in_valid = 1'b0;
        check("after_arst_pc4", 64'(out_pc4), 64'd500);
        check("after_arst_ins", 64'(out_ins), 64'h2222_0000);
        out_ready = 1'b1;
        tick();
        check("after_arst_drain", 64'(count), 64'd0);
        out_ready = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Decoupling buffer between the instruction-fetch stage and the decode stage of the MIPS core.
- Accepts (nextPC, instruction) pairs from fetch using a valid/ready handshake and holds them in a small FIFO.
- Presents the oldest entry to decode.
- A flush from branch/jump resolution discards every buffered entry, so wrong-path instructions never reach decode.

Parameters:
- DEPTH, 4, number of entries. Must be a power of two, minimum 2.
- PTR_W, 2, log2(DEPTH). Derived; not overridden independently.
- NOP_INS, 32'h0000_0000, instruction driven on out_ins when the queue is empty (sll $0,$0,0).

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-low reset.
- flush  input  1  discard all entries this cycle.
- in_valid  input  1  fetch offers an entry.
- in_ready  output  1  queue can accept an entry.
- in_pc4  input  32  PC+4 of the offered instruction.
- in_ins  input  32  offered instruction word.
- out_valid  output  1  head entry is valid.
- out_ready  input  1  decode consumes the head.
- out_pc4  output  32  PC+4 of the head entry.
- out_ins  output  32  head instruction.
- count  output  PTR_W+1  number of occupied entries, 0..DEPTH.

Behaviour:
- Reset (RST=0, asynchronous):
  - rd_ptr=0, wr_ptr=0, count=0.
  - out_valid=0, in_ready=1, out_pc4=0, out_ins=NOP_INS.
  - Storage contents are don't-care.
- Push and pop conditions:
  - push = in_valid & in_ready & ~flush.
  - pop = out_valid & out_ready & ~flush.
- Combinational status:
  - in_ready = (count != DEPTH).
  - in_ready has no combinational path from out_ready. A full queue refuses input even when a pop happens in the same cycle.
  - out_valid = (count != 0).
- Output data:
  - out_pc4/out_ins read the entry at rd_ptr combinationally.
  - When count==0, out_pc4=0 and out_ins=NOP_INS.
- Latency: an entry pushed at edge N appears on out_* after edge N (usable in cycle N+1). There is no same-cycle bypass from in_* to out_*.
- Per-edge update:
  - push: mem[wr_ptr] <= {in_pc4,in_ins}; wr_ptr increments, wrapping modulo DEPTH.
  - pop: rd_ptr increments, wrapping modulo DEPTH.
  - count <= count + push - pop.
  - Simultaneous push and pop with 0 < count < DEPTH: count is unchanged and both pointers advance.
- flush:
  - Takes priority over push and pop. rd_ptr, wr_ptr and count return to 0 on that edge.
  - in_valid in the flush cycle is ignored (the entry is dropped).
  - out_valid=0 in the following cycle.
- Boundary conditions:
  - Empty + out_ready=1: no pop, count stays 0.
  - Full + in_valid=1: no push, in_ready=0, storage unchanged.
  - Pointer wrap from DEPTH-1 to 0 is transparent to ordering.
- Reset mid-operation: all entries are lost immediately, asynchronously. Outputs take their reset values without waiting for CLK.
- Ordering: strict FIFO. Entries are never duplicated or reordered.

Decomposition:
- Shared constants go in common_param.vh alongside IMEM_SIZE:
  - NOP_INS value.
  - FETCHQ_DEPTH default.
- Storage is a natural sub-module: fetch_queue_mem. It has a DEPTH x 64-bit register array, a synchronous write port and an asynchronous read port, and is not reset.
- Pointer, count and handshake logic remain in fetch_queue.

Test Plan:
- Reset then idle:
  - Stimulus: RST low for 2 cycles, released; in_valid=0.
  - Response: count=0, out_valid=0, in_ready=1, out_ins=32'h0, out_pc4=0.
- Fill and drain:
  - Stimulus: push pc4=4,8,12,16 with ins=32'h20080001..32'h20080004 and out_ready=0.
  - Response: after the 4th edge count=4 and in_ready=0. A 5th push (pc4=20) is refused.
  - Then set out_ready=1. Response: decode sees pc4 4,8,12,16 in order, then out_valid=0.
- Streaming:
  - Stimulus: continuous push with out_ready=1 for 10 cycles.
  - Response: count holds at 1 after the first edge. out_pc4 lags in_pc4 by one cycle. Pointers wrap twice with no loss.
- Flush priority:
  - Stimulus: count=3, then flush=1 together with in_valid=1 (pc4=40) and out_ready=1.
  - Response: next cycle count=0 and out_valid=0. Entry 40 never appears at the output.
- Async reset mid-stream:
  - Stimulus: count=2, RST pulsed low between clock edges.
  - Response: count=0 and out_valid=0 immediately, before the next CLK edge.
- Empty pop / full push corner:
  - Stimulus: out_ready=1 at count=0.
  - Response: count stays 0.
  - Stimulus: at count=DEPTH, assert in_valid and out_ready together.
  - Response: only the pop occurs, and count=DEPTH-1.
